// File: rtl/ranger_pkg.sv
// Shared types and default timing for the parking-sensor ranging chain.
package ranger_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRIG      = 2'd1,
    WAIT_RISE = 2'd2,
    MEASURE   = 2'd3
  } state_t;

  // Reported when no echo arrived in time; downstream treats it as silent.
  localparam logic [11:0] DST_INVALID = 12'hFFF;

  // Defaults for a 50 MHz clock; the downstream stage derives its distance
  // thresholds from the same values.
  localparam int          TRIG_CYCLES_DEF   = 500;      // 10 us
  localparam int          CM_CYCLES_DEF     = 2900;     // 58 us per cm
  localparam int          PERIOD_CYCLES_DEF = 3000000;  // 60 ms
  localparam logic [11:0] MAX_CM_DEF        = 12'd1000;

endpackage

// File: rtl/echo_sync.sv
// Brings the asynchronous echo pin into the clk domain and flags its edges.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic echo,
  output logic echo_s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic echo_d;

  // Two-flop synchroniser followed by one delay stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      echo_s <= 1'b0;
      echo_d <= 1'b0;
    end else begin
      meta   <= echo;
      echo_s <= meta;
      echo_d <= echo_s;
    end
  end

  assign rise = echo_s & ~echo_d;
  assign fall = ~echo_s & echo_d;

endmodule

// File: rtl/ultrasonic_ranger.sv
// Periodically triggers an HC-SR04-style sensor and converts the echo pulse
// width into centimetres using a cycles-per-cm prescaler (no divider).
module ultrasonic_ranger
  import ranger_pkg::*;
#(
  parameter int          TRIG_CYCLES   = TRIG_CYCLES_DEF,
  parameter int          CM_CYCLES     = CM_CYCLES_DEF,
  parameter int          PERIOD_CYCLES = PERIOD_CYCLES_DEF,
  parameter logic [11:0] MAX_CM        = MAX_CM_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        echo,
  output logic        trig,
  output logic [11:0] binary_dst,
  output logic        dst_valid,
  output logic        timeout
);

  localparam logic [21:0] TRIG_LIM = 22'(TRIG_CYCLES);
  localparam logic [21:0] PER_LAST = 22'(PERIOD_CYCLES - 1);
  localparam logic [11:0] CM_LAST  = 12'(CM_CYCLES - 1);

  logic        echo_s;
  logic        rise;
  logic        fall;

  state_t      state;
  state_t      state_nxt;
  logic [21:0] pcnt;
  logic [11:0] presc;
  logic [11:0] cm;
  logic [11:0] cm_step;
  logic        presc_wrap;
  logic        period_end;

  logic        trig_nxt;
  logic        meas_clr;
  logic        meas_run;
  logic        load;
  logic [11:0] load_dst;
  logic        load_to;

  echo_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .echo   (echo),
    .echo_s (echo_s),
    .rise   (rise),
    .fall   (fall)
  );

  assign period_end = (pcnt == PER_LAST);
  assign presc_wrap = (presc == CM_LAST);
  // cm value after this cycle's prescaler step; the fall cycle itself still
  // counts toward the width, so the result loads this rather than cm.
  assign cm_step    = (presc_wrap && cm != MAX_CM) ? cm + 12'd1 : cm;

  // Free-running period counter; one trigger per wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt <= '0;
    else     pcnt <= period_end ? '0 : pcnt + 22'd1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and per-cycle control; timeout wins over a same-cycle fall.
  always_comb begin
    state_nxt = state;
    trig_nxt  = 1'b0;
    meas_clr  = 1'b0;
    meas_run  = 1'b0;
    load      = 1'b0;
    load_dst  = cm_step;
    load_to   = 1'b0;
    case (state)
      IDLE: begin
        if (pcnt == '0) begin
          state_nxt = TRIG;
          trig_nxt  = 1'b1;
        end
      end
      TRIG: begin
        if (pcnt < TRIG_LIM) trig_nxt = 1'b1;
        else                 state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (period_end) begin
          load      = 1'b1;
          load_dst  = DST_INVALID;
          load_to   = 1'b1;
          state_nxt = IDLE;
        end else if (rise) begin
          meas_clr  = 1'b1;
          state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        meas_run = 1'b1;
        if (period_end) begin
          load      = 1'b1;
          load_dst  = DST_INVALID;
          load_to   = 1'b1;
          state_nxt = IDLE;
        end else if (fall) begin
          load      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Prescaler divides echo-high time into whole centimetres, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      cm    <= '0;
    end else if (meas_clr) begin
      presc <= '0;
      cm    <= '0;
    end else if (meas_run) begin
      presc <= presc_wrap ? '0 : presc + 12'd1;
      cm    <= cm_step;
    end
  end

  // Registered outputs; binary_dst and timeout hold between updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig       <= 1'b0;
      binary_dst <= DST_INVALID;
      dst_valid  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      trig      <= trig_nxt;
      dst_valid <= load;
      if (load) begin
        binary_dst <= load_dst;
        timeout    <= load_to;
      end
    end
  end

endmodule
